// File: rtl/mmio_timer_if.sv
// mmio_timer_if: CPU external data bus as seen by the timer peripheral.
// The master side (CPU memory stage) drives address, select, direction and
// write data. The slave side returns read data combinationally.
interface mmio_timer_if;
    logic [31:0] addr;
    logic        cs;
    logic        wr_rd;
    logic [31:0] data_bus_write;
    logic [31:0] data_bus_read;

    modport master (
        output addr,
        output cs,
        output wr_rd,
        output data_bus_write,
        input  data_bus_read
    );

    modport slave (
        input  addr,
        input  cs,
        input  wr_rd,
        input  data_bus_write,
        output data_bus_read
    );
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 32-bit up-counter with compare match,
// optional auto-reload and a registered level interrupt.
// Register window (32 bytes at BASE_ADDR):
//   0x00 CTRL      bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN,
//                  bit8 MATCH (W1C), bit9 CAPF (W1C, capture build only)
//   0x04 PRESCALE  [PRESC_W-1:0]
//   0x08 COUNT     read/write
//   0x0C COMPARE   read/write
//   0x10 CAPTURE   read-only (reads 0 unless the capture unit is built)
//   0x14..0x1C     reserved, read 0
// Build option: define MMIO_TIMER_CAPTURE_EN to add the capture_in port,
// its synchronizer and the CAPTURE/CAPF logic.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned PRESC_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    mmio_timer_if.slave    bus,
`ifdef MMIO_TIMER_CAPTURE_EN
    input  logic           capture_in,
`endif
    output logic           irq
);

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_COUNT    = 3'd2,
        REG_COMPARE  = 3'd3,
        REG_CAPTURE  = 3'd4,
        REG_RSVD5    = 3'd5,
        REG_RSVD6    = 3'd6,
        REG_RSVD7    = 3'd7
    } reg_idx_e;

    // Decode
    logic        sel;
    logic        wr_en;
    logic        rd_en;
    reg_idx_e    reg_idx;
    logic        wr_ctrl;
    logic        wr_presc;
    logic        wr_count;
    logic        wr_compare;
    logic [31:0] wdata;
    logic        unused_addr_bits;

    // Architectural state
    logic               en;
    logic               auto_reload;
    logic               irq_en;
    logic               match;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;
    logic [31:0]        count;
    logic [31:0]        compare;

    // Next-state values
    logic               tick;
    logic               hit;
    logic               en_next;
    logic               auto_reload_next;
    logic               irq_en_next;
    logic               match_next;
    logic [PRESC_W-1:0] presc_next;
    logic [PRESC_W-1:0] pcnt_next;
    logic [31:0]        count_next;
    logic [31:0]        compare_next;
    logic               irq_next;

    // Capture unit (or its constant stand-ins)
    logic               capf_val;
    logic [31:0]        capture_val;

    // The byte lane bits carry no meaning for a word-only register file.
    assign unused_addr_bits = ^bus.addr[1:0];

    assign sel        = bus.cs && (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign wr_en      = sel && bus.wr_rd;
    assign rd_en      = sel && !bus.wr_rd;
    assign reg_idx    = reg_idx_e'(bus.addr[4:2]);
    assign wdata      = bus.data_bus_write;
    assign wr_ctrl    = wr_en && (reg_idx == REG_CTRL);
    assign wr_presc   = wr_en && (reg_idx == REG_PRESCALE);
    assign wr_count   = wr_en && (reg_idx == REG_COUNT);
    assign wr_compare = wr_en && (reg_idx == REG_COMPARE);

`ifdef MMIO_TIMER_CAPTURE_EN
    // cap_sync[0..1] synchronize capture_in; cap_sync[2] is the edge-detect flop.
    logic [2:0]  cap_sync;
    logic        cap_rise;
    logic        capf;
    logic        capf_next;
    logic [31:0] capture;

    assign cap_rise    = cap_sync[1] && !cap_sync[2];
    assign capf_val    = capf;
    assign capture_val = capture;

    // Synchronizer chain and edge detector for the asynchronous capture strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_sync <= 3'b000;
        end else begin
            cap_sync <= {cap_sync[1:0], capture_in};
        end
    end

    // Capture flag: a new capture beats a same-cycle write-1-to-clear.
    always_comb begin
        capf_next = capf;
        if (cap_rise) begin
            capf_next = 1'b1;
        end else if (wr_ctrl && wdata[9]) begin
            capf_next = 1'b0;
        end
    end

    // CAPTURE takes the counter value as it stood before this cycle's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            capture <= 32'd0;
            capf    <= 1'b0;
        end else begin
            if (cap_rise) begin
                capture <= count;
            end
            capf <= capf_next;
        end
    end
`else
    assign capf_val    = 1'b0;
    assign capture_val = 32'd0;
`endif

    // Next-state logic for prescaler, counter, match flag and control bits.
    always_comb begin
        tick             = en && (pcnt == presc);
        hit              = tick && !wr_count && (count == compare);
        en_next          = en;
        auto_reload_next = auto_reload;
        irq_en_next      = irq_en;
        match_next       = match;
        presc_next       = presc;
        pcnt_next        = pcnt;
        count_next       = count;
        compare_next     = compare;

        if (wr_ctrl) begin
            en_next          = wdata[0];
            auto_reload_next = wdata[1];
            irq_en_next      = wdata[2];
        end

        if (hit) begin
            match_next = 1'b1;
        end else if (wr_ctrl && wdata[8]) begin
            match_next = 1'b0;
        end

        if (wr_presc) begin
            presc_next = wdata[PRESC_W-1:0];
        end

        if (wr_compare) begin
            compare_next = wdata;
        end

        if (wr_count || wr_presc || tick) begin
            pcnt_next = '0;
        end else if (en) begin
            pcnt_next = pcnt + PRESC_W'(1);
        end

        if (wr_count) begin
            count_next = wdata;
        end else if (tick) begin
            if (hit && auto_reload) begin
                count_next = 32'd0;
            end else begin
                count_next = count + 32'd1;
            end
        end

        irq_next = (match_next || capf_val_next()) && irq_en_next;
    end

    // Helper so the interrupt equation reads the same in both builds.
    function automatic logic capf_val_next();
`ifdef MMIO_TIMER_CAPTURE_EN
        return capf_next;
`else
        return 1'b0;
`endif
    endfunction

    // State registers; reset overrides any bus write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            match       <= 1'b0;
            presc       <= '0;
            pcnt        <= '0;
            count       <= 32'd0;
            compare     <= 32'hFFFF_FFFF;
            irq         <= 1'b0;
        end else begin
            en          <= en_next;
            auto_reload <= auto_reload_next;
            irq_en      <= irq_en_next;
            match       <= match_next;
            presc       <= presc_next;
            pcnt        <= pcnt_next;
            count       <= count_next;
            compare     <= compare_next;
            irq         <= irq_next;
        end
    end

    // Combinational read mux; anything not selected as a read returns 0.
    always_comb begin
        bus.data_bus_read = 32'd0;
        if (rd_en) begin
            case (reg_idx)
                REG_CTRL: begin
                    bus.data_bus_read[0] = en;
                    bus.data_bus_read[1] = auto_reload;
                    bus.data_bus_read[2] = irq_en;
                    bus.data_bus_read[8] = match;
                    bus.data_bus_read[9] = capf_val;
                end
                REG_PRESCALE: bus.data_bus_read[PRESC_W-1:0] = presc;
                REG_COUNT:    bus.data_bus_read = count;
                REG_COMPARE:  bus.data_bus_read = compare;
                REG_CAPTURE:  bus.data_bus_read = capture_val;
                default:      bus.data_bus_read = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed bench for mmio_timer. Expected values are pushed
// into a scoreboard queue as each read is issued and popped when the bus
// returns data; the irq line is checked through the same queue.
module tb_mmio_timer;

    localparam logic [31:0] A_CTRL     = 32'h0000_1000;
    localparam logic [31:0] A_PRESCALE = 32'h0000_1004;
    localparam logic [31:0] A_COUNT    = 32'h0000_1008;
    localparam logic [31:0] A_COMPARE  = 32'h0000_100C;
    localparam logic [31:0] A_CAPTURE  = 32'h0000_1010;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic irq;
`ifdef MMIO_TIMER_CAPTURE_EN
    logic capture_in;
`endif

    exp_t exp_q[$];
    int   assertions_evaluated = 0;
    int   failures = 0;

    mmio_timer_if bus_if ();

    mmio_timer #(
        .BASE_ADDR (32'h0000_1000),
        .PRESC_W   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
`ifdef MMIO_TIMER_CAPTURE_EN
        .capture_in (capture_in),
`endif
        .irq        (irq)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        assertions_evaluated++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_underflow observed=%h expected=queued_entry", observed);
            return;
        end
        e = exp_q.pop_front();
        assert (observed === e.value) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
        end
    endtask

    // Issue a read (cs_val lets a deselected read be tried) and score it.
    task automatic applyStimulus(input string tag, input logic cs_val,
                                 input logic [31:0] a, input logic [31:0] expected);
        exp_t e;
        e.tag   = tag;
        e.value = expected;
        exp_q.push_back(e);
        bus_if.addr           = a;
        bus_if.cs             = cs_val;
        bus_if.wr_rd          = 1'b0;
        bus_if.data_bus_write = 32'd0;
        #1;
        checkOutput(bus_if.data_bus_read);
        bus_if.cs = 1'b0;
    endtask

    task automatic expectIrq(input string tag, input logic expected);
        exp_t e;
        e.tag   = tag;
        e.value = {31'd0, expected};
        exp_q.push_back(e);
        checkOutput({31'd0, irq});
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.addr           = a;
        bus_if.cs             = 1'b1;
        bus_if.wr_rd          = 1'b1;
        bus_if.data_bus_write = d;
        @(posedge clk);
        #1;
        bus_if.cs    = 1'b0;
        bus_if.wr_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst                   = 1'b1;
        bus_if.addr           = 32'd0;
        bus_if.cs             = 1'b0;
        bus_if.wr_rd          = 1'b0;
        bus_if.data_bus_write = 32'd0;
`ifdef MMIO_TIMER_CAPTURE_EN
        capture_in            = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset values and decode");
        applyStimulus("rst_ctrl",     1'b1, A_CTRL,     32'h0000_0000);
        applyStimulus("rst_prescale", 1'b1, A_PRESCALE, 32'h0000_0000);
        applyStimulus("rst_count",    1'b1, A_COUNT,    32'h0000_0000);
        applyStimulus("rst_compare",  1'b1, A_COMPARE,  32'hFFFF_FFFF);
        applyStimulus("rst_capture",  1'b1, A_CAPTURE,  32'h0000_0000);
        expectIrq("rst_irq", 1'b0);
        idle(1);
        applyStimulus("rsvd_14",      1'b1, 32'h0000_1014, 32'h0000_0000);
        applyStimulus("rsvd_1c",      1'b1, 32'h0000_101C, 32'h0000_0000);
        applyStimulus("byte_lane",    1'b1, 32'h0000_100F, 32'hFFFF_FFFF);
        idle(1);
        applyStimulus("cs_low",       1'b0, A_COMPARE,      32'h0000_0000);
        applyStimulus("out_window",   1'b1, 32'h0000_200C,  32'h0000_0000);
        bus_write(32'h0000_1014, 32'hDEAD_BEEF);
        applyStimulus("rsvd_wr_ign",  1'b1, 32'h0000_1014, 32'h0000_0000);
        bus_write(32'h0000_2008, 32'h1234_5678);
        applyStimulus("other_win_wr", 1'b1, A_COUNT,       32'h0000_0000);

        $display("[TB] prescaler 3, run and stop");
        bus_write(A_PRESCALE, 32'h0000_0003);
        bus_write(A_COUNT,    32'h0000_0000);
        bus_write(A_CTRL,     32'h0000_0001);
        idle(20);
        applyStimulus("presc_count5", 1'b1, A_COUNT, 32'h0000_0005);
        bus_write(A_CTRL, 32'h0000_0000);
        applyStimulus("stop_count",   1'b1, A_COUNT, 32'h0000_0005);
        idle(10);
        applyStimulus("hold_count",   1'b1, A_COUNT,    32'h0000_0005);
        applyStimulus("presc_rd",     1'b1, A_PRESCALE, 32'h0000_0003);

        $display("[TB] compare 4 with auto-reload and irq");
        bus_write(A_PRESCALE, 32'h0000_0000);
        bus_write(A_COMPARE,  32'h0000_0004);
        bus_write(A_COUNT,    32'h0000_0000);
        bus_write(A_CTRL,     32'h0000_0007);
        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("seq_%0d", i), 1'b1, A_COUNT, i[31:0]);
            idle(1);
        end
        applyStimulus("reload_0",     1'b1, A_COUNT, 32'h0000_0000);
        applyStimulus("match_set",    1'b1, A_CTRL,  32'h0000_0107);
        expectIrq("irq_set", 1'b1);
        bus_write(A_CTRL, 32'h0000_0107);
        applyStimulus("match_clr",    1'b1, A_CTRL,  32'h0000_0007);
        expectIrq("irq_clr", 1'b0);
        idle(3);
        applyStimulus("pre_hit_4",    1'b1, A_COUNT, 32'h0000_0004);
        bus_write(A_CTRL, 32'h0000_0107);
        applyStimulus("set_wins",     1'b1, A_CTRL,  32'h0000_0107);
        expectIrq("set_wins_irq", 1'b1);
        bus_write(A_CTRL, 32'h0000_0100);
        applyStimulus("disabled",     1'b1, A_CTRL,  32'h0000_0000);
        expectIrq("irq_off", 1'b0);

        $display("[TB] wrap without match, then match at 5");
        bus_write(A_COMPARE, 32'h0000_0005);
        bus_write(A_COUNT,   32'hFFFF_FFFE);
        bus_write(A_CTRL,    32'h0000_0001);
        applyStimulus("wrap_fe",      1'b1, A_COUNT, 32'hFFFF_FFFE);
        idle(1);
        applyStimulus("wrap_ff",      1'b1, A_COUNT, 32'hFFFF_FFFF);
        idle(1);
        applyStimulus("wrap_0",       1'b1, A_COUNT, 32'h0000_0000);
        applyStimulus("wrap_nomatch", 1'b1, A_CTRL,  32'h0000_0001);
        idle(5);
        applyStimulus("at_5",         1'b1, A_COUNT, 32'h0000_0005);
        idle(1);
        applyStimulus("past_6",       1'b1, A_COUNT, 32'h0000_0006);
        applyStimulus("match_noar",   1'b1, A_CTRL,  32'h0000_0101);
        expectIrq("irq_masked", 1'b0);

        $display("[TB] COUNT write on a tick cycle");
        bus_write(A_COUNT, 32'h0000_0100);
        applyStimulus("load_override", 1'b1, A_COUNT, 32'h0000_0100);
        idle(1);
        applyStimulus("load_resume",   1'b1, A_COUNT, 32'h0000_0101);

        $display("[TB] reset mid-count with concurrent write");
        bus_write(A_CTRL, 32'h0000_0005);
        expectIrq("irq_pre_rst", 1'b1);
        rst = 1'b1;
        bus_write(A_COMPARE, 32'h0000_0055);
        rst = 1'b0;
        applyStimulus("mid_rst_ctrl",    1'b1, A_CTRL,     32'h0000_0000);
        applyStimulus("mid_rst_presc",   1'b1, A_PRESCALE, 32'h0000_0000);
        applyStimulus("mid_rst_count",   1'b1, A_COUNT,    32'h0000_0000);
        applyStimulus("mid_rst_compare", 1'b1, A_COMPARE,  32'hFFFF_FFFF);
        expectIrq("mid_rst_irq", 1'b0);

`ifdef MMIO_TIMER_CAPTURE_EN
        $display("[TB] capture strobe");
        bus_write(A_CTRL,  32'h0000_0005);
        bus_write(A_COUNT, 32'h0000_0020);
        capture_in = 1'b1;
        idle(1);
        capture_in = 1'b0;
        idle(2);
        applyStimulus("capture_val", 1'b1, A_CAPTURE, 32'h0000_0022);
        applyStimulus("capf_set",    1'b1, A_CTRL,    32'h0000_0205);
        expectIrq("capture_irq", 1'b1);
`endif

        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions_evaluated, failures);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer/compare peripheral on the CPU external data bus, directly downstream of the CPU memory stage.
- Consumes the stage's addr, cs, wr_rd and data_bus_write outputs.
- Returns 32-bit read data on data_bus_read combinationally, within the same cycle, so the memory-stage write-back mux can sample it.
- Provides a prescaled 32-bit up-counter, compare match, auto-reload and a level interrupt.

Parameters:
- BASE_ADDR, 32'h0000_1000, base of the 32-byte register window; bits [4:0] are ignored.
- PRESC_W, 16, width of the prescaler register and the prescaler counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  32  byte address from the CPU memory stage.
- cs  input  1  external-bus select from the CPU address decoder.
- wr_rd  input  1  1 = write, 0 = read.
- data_bus_write  input  32  write data.
- data_bus_read  output  32  read data, combinational.
- irq  output  1  level interrupt, registered.
- capture_in  input  1  asynchronous capture strobe; present only with MMIO_TIMER_CAPTURE_EN.

Behaviour:
- Decoding:
  - sel = cs & (addr[31:5] == BASE_ADDR[31:5]).
  - Register index = addr[4:2]; addr[1:0] ignored.
  - Writes act at the clock edge when sel & wr_rd.
  - Reads: data_bus_read = register value when sel & !wr_rd, else 0.
  - Reads have no side effects.
- Register map:
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bit8 MATCH (read; write-1-to-clear). Other bits read 0.
  - 0x04 PRESCALE: [PRESC_W-1:0]; upper bits read 0.
  - 0x08 COUNT: read/write.
  - 0x0C COMPARE: read/write.
  - 0x10 CAPTURE: read-only.
  - 0x14–0x1C: read 0, writes ignored.
- Reset values: CTRL = 0, PRESCALE = 0, COUNT = 0, COMPARE = 32'hFFFF_FFFF, CAPTURE = 0, prescaler counter = 0, irq = 0.
- Prescaler:
  - When EN = 1, pcnt counts 0..PRESCALE.
  - tick = EN & (pcnt == PRESCALE); on tick, pcnt <= 0.
  - When EN = 0, pcnt holds and no tick occurs.
  - PRESCALE = 0 gives a tick every cycle.
- Counter on tick:
  - If COUNT == COMPARE: MATCH <= 1, and COUNT <= 0 when AUTO_RELOAD, else COUNT + 1.
  - Otherwise COUNT <= COUNT + 1.
  - Wrap from FFFF_FFFF to 0 is silent, apart from the match rule.
- Match period with AUTO_RELOAD: (COMPARE + 1) × (PRESCALE + 1) cycles.
- Write to COUNT:
  - Loads COUNT and clears pcnt.
  - Overrides a same-cycle tick; no match is evaluated that cycle.
- Write to PRESCALE: clears pcnt.
- Write to CTRL:
  - Updates EN, AUTO_RELOAD and IRQ_EN.
  - Writing 1 to bit8 clears MATCH. If a match occurs in the same cycle, set wins and MATCH stays 1.
- irq: registered, irq <= MATCH_next & IRQ_EN_next, so it asserts one cycle after the tick that sets MATCH.
- Reset mid-count: all state returns to reset values on the next edge; rst overrides any bus write.
- Latency:
  - Read data is visible in the same cycle that addr is presented.
  - A write is visible to reads from the following cycle.

Optional Feature:
- MMIO_TIMER_CAPTURE_EN defined:
  - capture_in port exists and passes through a 2-flop synchronizer plus an edge-detect flop.
  - On a synchronized rising edge, CAPTURE <= COUNT (pre-update value of that cycle).
  - CTRL bit9 CAPF sets on capture and is write-1-to-clear; set wins over clear.
  - irq <= (MATCH | CAPF) & IRQ_EN.
  - Capture-to-CAPTURE latency: 3 cycles from the capture_in rise.
- Undefined:
  - No capture_in port and no synchronizer logic.
  - 0x10 reads 0; CTRL bit9 reads 0.
  - irq is as in Behaviour.

Test Plan:
- Reset then read all offsets -> CTRL = 0, PRESCALE = 0, COUNT = 0, COMPARE = FFFF_FFFF, CAPTURE = 0, irq = 0; reads with cs = 0 or addr outside the window -> 0.
- PRESCALE = 3, COUNT = 0, CTRL = 1 -> COUNT = 5 after 20 cycles; clear EN -> COUNT holds at 5 for 10 cycles.
- PRESCALE = 0, COMPARE = 4, CTRL = 0x7 -> COUNT sequence 0,1,2,3,4,0; MATCH and irq rise one cycle after the tick at COUNT = 4; write 0x107 to CTRL -> MATCH = 0, irq = 0 the next cycle.
- COUNT = FFFF_FFFE, COMPARE = 5, AUTO_RELOAD = 0, EN = 1, PRESCALE = 0 -> COUNT goes FFFF_FFFF, 0, 1, no MATCH; MATCH sets on the tick at COUNT = 5 and COUNT becomes 6.
- Simultaneous events:
  - COUNT write of 0x100 on a tick cycle -> COUNT = 0x100 with no increment.
  - W1C of MATCH on a cycle where a match also occurs -> MATCH stays 1.
  - rst asserted mid-count with a concurrent write -> all reset values.
- With MMIO_TIMER_CAPTURE_EN: capture_in pulse while COUNT = 0x20, PRESCALE = 0 -> CAPTURE = 0x22, CAPF = 1, irq = 1 when IRQ_EN = 1.
